// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified memory port arbiter.
// State encoding is shared with control and hazard logic.
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2,
      RESP    = 2'd3
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Transaction watchdog: counts busy cycles, flags the last allowed one.
// Holds at the limit so expire stays asserted until cleared.
module arb_timeout_cnt #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en && cnt != LAST) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = en && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (IF) and data (MEM).
// One latched transaction at a time; MEM has priority up to a streak limit.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DM_STREAK   = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              bus_err
);

   localparam int SW = $clog2(DM_STREAK + 1);
   localparam logic [SW-1:0] SMAX = SW'(DM_STREAK);

   arb_state_e state_q, state_d;
   logic [SW-1:0] streak_q;
   logic grant_if, grant_dm;
   logic busy, ack_ok, expire, tmo, done;

   assign busy   = (state_q == BUSY_IF) || (state_q == BUSY_DM);
   assign ack_ok = mem_ack && mem_req;

   arb_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_tmo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (grant_if || grant_dm),
      .en     (busy),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_if = 1'b0;
      grant_dm = 1'b0;
      tmo      = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (dm_req && (!if_req || streak_q < SMAX)) begin
               grant_dm = 1'b1;
               state_d  = BUSY_DM;
            end else if (if_req) begin
               grant_if = 1'b1;
               state_d  = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_DM: begin
            // A real ack wins over a timeout landing in the same cycle
            if (ack_ok) begin
               done    = 1'b1;
               state_d = RESP;
            end else if (expire) begin
               done    = 1'b1;
               tmo     = 1'b1;
               state_d = RESP;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         bus_err   <= 1'b0;
         streak_q  <= '0;
      end else begin
         if_ack   <= 1'b0;
         dm_ack   <= 1'b0;
         if_rdata <= '0;
         dm_rdata <= '0;
         bus_err  <= 1'b0;
         if (grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (!if_req) begin
               streak_q <= '0;
            end else if (streak_q != SMAX) begin
               streak_q <= streak_q + 1'b1;
            end
         end
         if (grant_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            streak_q  <= '0;
         end
         if (done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            bus_err <= tmo;
            if (state_q == BUSY_IF) begin
               if_ack   <= 1'b1;
               if_rdata <= tmo ? '0 : mem_rdata;
            end else begin
               dm_ack   <= 1'b1;
               dm_rdata <= (tmo || mem_we) ? '0 : mem_rdata;
            end
         end
      end
   end

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus
// hand-written arbitration, timeout and reset sequences.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        stall_if;
   logic        stall_mem;
   logic        bus_err;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .DM_STREAK(4), .TIMEOUT_CYC(64)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // memory model: ack ack_delay cycles after mem_req first seen (-1 = never)
   bit          model_on = 1'b1;
   int          ack_delay = 0;
   logic [31:0] ack_data = '0;
   int          req_hi = 0;

   task automatic tick();
      if (model_on) begin
         if (mem_req) begin
            mem_ack   = (req_hi == ack_delay);
            mem_rdata = ack_data;
            req_hi++;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            req_hi    = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          dm;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      logic [31:0] exp_rdata;
      int          exp_ack_cyc;
      bit          exp_err;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input vec_t v, input string tag);
      int cyc = 0;
      int hi = 0;
      bit seen = 1'b0;
      logic [31:0] got_rd = '0;
      logic got_err = 1'b0;
      logic got_stall = 1'b1;
      ack_delay = v.delay;
      ack_data  = v.rdata;
      if (v.dm) begin
         dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      #1;
      check($sformatf("%s.stall0", tag), v.dm ? stall_mem : stall_if, 1);
      while (!seen && cyc < 200) begin
         tick();
         cyc++;
         if (mem_req) hi++;
         if (cyc == 1) begin
            check($sformatf("%s.addr", tag), mem_addr, v.addr);
            check($sformatf("%s.we", tag), mem_we, v.dm ? v.we : 1'b0);
            if (v.we) check($sformatf("%s.wdata", tag), mem_wdata, v.wdata);
            dm_addr = ~v.addr; dm_wdata = ~v.wdata; dm_we = ~v.we;
            if_addr = ~v.addr;
         end
         if (cyc == 2 && mem_req) begin
            check($sformatf("%s.hold_addr", tag), mem_addr, v.addr);
            check($sformatf("%s.hold_we", tag), mem_we, v.dm ? v.we : 1'b0);
         end
         if (v.dm ? dm_ack : if_ack) begin
            seen      = 1'b1;
            got_rd    = v.dm ? dm_rdata : if_rdata;
            got_err   = bus_err;
            got_stall = v.dm ? stall_mem : stall_if;
         end
      end
      check($sformatf("%s.ack_cyc", tag), seen ? cyc : -1, v.exp_ack_cyc);
      check($sformatf("%s.rdata", tag), got_rd, v.exp_rdata);
      check($sformatf("%s.bus_err", tag), got_err, v.exp_err);
      check($sformatf("%s.req_cycles", tag), hi, v.exp_ack_cyc - 1);
      check($sformatf("%s.stall_ack", tag), got_stall, 0);
      dm_req = 1'b0; if_req = 1'b0; dm_we = 1'b0;
      tick();
   endtask

   // order bit i = 1 means the i-th grant must go to MEM
   task automatic grant_seq(input int n, input bit hold_dm,
                            input logic [9:0] order, input string tag);
      int cyc = 0;
      int grants = 0;
      int n_dm = 0;
      int n_if = 0;
      bit prev = 1'b0;
      ack_delay = 0;
      ack_data  = 32'h8C01_0004;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1000_0010;
      if_req = 1'b1; if_addr = 32'h0040_0004;
      while ((n_dm + n_if) < n && cyc < 300) begin
         tick();
         cyc++;
         if (mem_req && !prev) begin
            if (grants < 10)
               check($sformatf("%s.grant%0d", tag, grants), mem_addr,
                     order[grants] ? 32'h1000_0010 : 32'h0040_0004);
            if (grants == 0) check($sformatf("%s.we0", tag), mem_we, 0);
            grants++;
         end
         prev = mem_req;
         if (dm_ack) begin
            n_dm++;
            if (!hold_dm) dm_req = 1'b0;
         end
         if (if_ack) n_if++;
      end
      dm_req = 1'b0; if_req = 1'b0;
      tick();
      check($sformatf("%s.grants", tag), grants, n);
      check($sformatf("%s.dm_acks", tag), n_dm, $countones(order[9:0] & ((10'd1 << n) - 10'd1)));
      check($sformatf("%s.if_acks", tag), n_if, n - $countones(order[9:0] & ((10'd1 << n) - 10'd1)));
   endtask

   initial begin
      vecs[0] = '{0, 0, 32'h0040_0000, 32'h0, 32'h2008_0005, 2, 32'h2008_0005, 4, 0};
      vecs[1] = '{1, 0, 32'h1000_0010, 32'h0, 32'h8C01_0004, 0, 32'h8C01_0004, 2, 0};
      vecs[2] = '{1, 1, 32'h1000_0020, 32'hDEAD_BEEF, 32'h1234_5678, 1, 32'h0, 3, 0};
      vecs[3] = '{0, 0, 32'h0040_0010, 32'h0, 32'hAC22_0008, 5, 32'hAC22_0008, 7, 0};
      vecs[4] = '{1, 0, 32'h1000_0040, 32'h0, 32'hBAD0_BAD0, -1, 32'h0, 65, 1};

      repeat (2) @(posedge clk);
      #1;
      check("rst.mem_req", mem_req, 0);
      check("rst.mem_we", mem_we, 0);
      check("rst.mem_addr", mem_addr, 0);
      check("rst.if_ack", if_ack, 0);
      check("rst.dm_ack", dm_ack, 0);
      check("rst.bus_err", bus_err, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      grant_seq(2, 1'b0, 10'b00_0000_0001, "simul");
      grant_seq(10, 1'b1, 10'b01_1110_1111, "streak");

      ack_delay = -1;
      if_req = 1'b1; if_addr = 32'h0040_0008;
      tick();
      tick();
      check("mrst.pre_req", mem_req, 1);
      rst_n = 1'b0;
      #1;
      check("mrst.mem_req", mem_req, 0);
      check("mrst.mem_addr", mem_addr, 0);
      check("mrst.if_ack", if_ack, 0);
      check("mrst.bus_err", bus_err, 0);
      if_req = 1'b0;
      model_on = 1'b0;
      mem_ack = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 32'h1234_0000;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      check("late.if_ack", if_ack, 0);
      check("late.mem_req", mem_req, 0);
      @(posedge clk);
      #1;
      check("late.if_ack2", if_ack, 0);
      check("late.dm_ack2", dm_ack, 0);
      model_on = 1'b1;
      run_vec(vecs[0], "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
